// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt sequencer.
package irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
  localparam int NUM_SRC_DEF = 4;
  localparam logic [31:0] MASK_RESET = '1;
  function automatic int cause_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins.
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (req_i[i]) idx_o = W'(i);
  end
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: prioritised IRQ request/service handshake; IRQ_SEQUENCER_LEVEL_EN selects level-sensitive sources.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int CAUSE_W = cause_w(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  input  logic               pc_super_i,
  input  logic               irq_taken_i,
  input  logic               svc_exit_i,
  output logic               irq_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] mask_o,
  output logic               in_service_o
);
  state_e state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d, win;
  logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d;
  logic valid;
  irq_prio_enc #(.N(NUM_SRC), .W(CAUSE_W)) u_enc (
    .req_i  (pending_q & mask_q),
    .valid_o(valid),
    .idx_o  (win)
  );
`ifdef IRQ_SEQUENCER_LEVEL_EN
  assign pending_d = irq_src_i;
`else
  logic [NUM_SRC-1:0] src_q, clr;
  assign clr = (state_q == REQ && irq_taken_i) ? NUM_SRC'(1) << cause_q : '0;
  // a fresh edge on the bit being cleared keeps it pending
  assign pending_d = (pending_q & ~clr) | (irq_src_i & ~src_q);
  always_ff @(posedge clk_i) src_q <= reset_i ? '0 : irq_src_i;
`endif
  assign mask_d = mask_we_i ? mask_wdata_i : mask_q;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (valid && !pc_super_i) begin
        state_d = REQ;
        cause_d = win;
      end
      REQ: state_d = irq_taken_i ? SERVICE : (pc_super_i || !mask_q[cause_q]) ? IDLE : REQ;
      SERVICE: state_d = svc_exit_i ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cause_q <= '0;
      pending_q <= '0;
      mask_q <= MASK_RESET[NUM_SRC-1:0];
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pending_q <= pending_d;
      mask_q <= mask_d;
    end
  end
  assign irq_o = state_q == REQ;
  assign in_service_o = state_q == SERVICE;
  assign cause_o = cause_q;
  assign pending_o = pending_q;
  assign mask_o = mask_q;
endmodule
